// File: rtl/pipelined_address_generator.sv
// Elastic address-generation unit for the execute stage.
// Stage 0 computes rs1+imm or pc+imm, the link address and the alignment/legality
// flags from the incoming request. The remaining stages only carry the result
// forward under a valid/ready handshake, so a stalled consumer backs the pipe up
// without losing or duplicating anything.
module pipelined_address_generator #(
    parameter int XLEN       = 32,
    parameter int PIPE_DEPTH = 2,
    parameter int IALIGN     = 4,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  immediate,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  address,
    output logic [XLEN-1:0]  link_address,
    output logic             misaligned,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [XLEN-1:0]  address;
        logic [XLEN-1:0]  link_address;
        logic             misaligned;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } result_t;

    logic [XLEN-1:0]       rs1_sum;
    logic [XLEN-1:0]       pc_sum;
    logic [XLEN-1:0]       addr_calc;
    logic                  mis_calc;
    logic                  ill_calc;
    result_t               calc;
    result_t               stage_d [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] stage_v;
    logic [PIPE_DEPTH-1:0] stage_ready;

    // The unsigned-load bit only selects zero-extension downstream; it never
    // changes the address or the flags here.
    logic unused_funct3_bit2;
    assign unused_funct3_bit2 = funct3[2];

    assign rs1_sum = rs1 + immediate;
    assign pc_sum  = pc + immediate;

    // Select the base, shape the target and derive alignment/legality from the sum.
    always_comb begin
        addr_calc = '0;
        mis_calc  = 1'b0;
        ill_calc  = 1'b0;
        case (opcode)
            OP_LOAD, OP_STORE: begin
                addr_calc = rs1_sum;
                case (funct3[1:0])
                    2'b00:   mis_calc = 1'b0;
                    2'b01:   mis_calc = rs1_sum[0];
                    2'b10:   mis_calc = |rs1_sum[1:0];
                    default: begin
                        if (XLEN == 64) begin
                            mis_calc = |rs1_sum[2:0];
                        end else begin
                            ill_calc = 1'b1;
                        end
                    end
                endcase
            end
            OP_JALR: begin
                addr_calc = {rs1_sum[XLEN-1:1], 1'b0};
                mis_calc  = (IALIGN == 4) ? rs1_sum[1] : 1'b0;
            end
            OP_JAL, OP_BRANCH: begin
                addr_calc = pc_sum;
                mis_calc  = (IALIGN == 4) ? pc_sum[1] : 1'b0;
            end
            OP_AUIPC: begin
                addr_calc = pc_sum;
            end
            default: begin
                ill_calc = 1'b1;
            end
        endcase
    end

    assign calc.address      = addr_calc;
    assign calc.link_address = pc + XLEN'(4);
    assign calc.misaligned   = mis_calc;
    assign calc.illegal      = ill_calc;
    assign calc.tag          = in_tag;

    // A stage may load when it is empty or when some stage downstream of it is empty
    // or the consumer is taking the last one; this is the unrolled ready chain.
    always_comb begin
        stage_ready = '0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            stage_ready[i] = out_ready;
            for (int j = i; j < PIPE_DEPTH; j++) begin
                if (!stage_v[j]) begin
                    stage_ready[i] = 1'b1;
                end
            end
        end
    end

    assign in_ready = stage_ready[0];

    // Advance the pipeline; flush kills every valid bit including a same-cycle accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_v <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                stage_d[i] <= '0;
            end
        end else begin
            if (stage_ready[0]) begin
                stage_v[0] <= in_valid;
                if (in_valid) begin
                    stage_d[0] <= calc;
                end
            end
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                if (stage_ready[i]) begin
                    stage_v[i] <= stage_v[i-1];
                    if (stage_v[i-1]) begin
                        stage_d[i] <= stage_d[i-1];
                    end
                end
            end
            if (flush) begin
                stage_v <= '0;
            end
        end
    end

    assign out_valid    = stage_v[PIPE_DEPTH-1];
    assign address      = stage_d[PIPE_DEPTH-1].address;
    assign link_address = stage_d[PIPE_DEPTH-1].link_address;
    assign misaligned   = stage_d[PIPE_DEPTH-1].misaligned;
    assign illegal      = stage_d[PIPE_DEPTH-1].illegal;
    assign out_tag      = stage_d[PIPE_DEPTH-1].tag;

endmodule

// File: tb/tb_pipelined_address_generator.sv
// Scoreboard bench for pipelined_address_generator (XLEN=32, PIPE_DEPTH=2, IALIGN=4).
// Accepted requests push their hand-computed result into a queue; an independent
// monitor pops and compares on every output handshake and checks stall stability.
module tb_pipelined_address_generator;

    localparam int XLEN       = 32;
    localparam int PIPE_DEPTH = 2;
    localparam int IALIGN     = 4;
    localparam int TAG_W      = 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] link_address;
        logic        misaligned;
        logic        illegal;
        logic [4:0]  tag;
    } txn_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  immediate;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  address;
    logic [XLEN-1:0]  link_address;
    logic             misaligned;
    logic             illegal;
    logic [TAG_W-1:0] out_tag;

    txn_t expected_q[$];
    int   checks = 0;
    int   errors = 0;
    txn_t prev_out;
    logic prev_stalled = 1'b0;
    txn_t cur_out;

    pipelined_address_generator #(
        .XLEN(XLEN), .PIPE_DEPTH(PIPE_DEPTH), .IALIGN(IALIGN), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .rs1(rs1), .pc(pc),
        .immediate(immediate), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .address(address), .link_address(link_address),
        .misaligned(misaligned), .illegal(illegal), .out_tag(out_tag)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: compare each output handshake with the scoreboard head and make sure
    // a stalled result does not move.
    always @(negedge clk) begin
        cur_out = {address, link_address, misaligned, illegal, out_tag};
        if (!reset || flush) begin
            prev_stalled = 1'b0;
        end else begin
            if (out_valid && !out_ready && prev_stalled) begin
                checkOutput("stall_hold", cur_out, prev_out);
            end
            if (out_valid && out_ready) begin
                if (expected_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got 0x%0h, expected no output", cur_out);
                end else begin
                    checkOutput("out_txn", cur_out, expected_q.pop_front());
                end
            end
            prev_stalled = out_valid && !out_ready;
            prev_out     = cur_out;
        end
    end

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [31:0] r1, input logic [31:0] p,
                                 input logic [31:0] imm, input logic [4:0] tag,
                                 input logic [31:0] exp_addr, input logic [31:0] exp_link,
                                 input logic exp_mis, input logic exp_ill);
        bit   accepted;
        txn_t exp_txn;
        accepted  = 1'b0;
        opcode    = op;
        funct3    = f3;
        rs1       = r1;
        pc        = p;
        immediate = imm;
        in_tag    = tag;
        in_valid  = 1'b1;
        for (int n = 0; n < 40 && !accepted; n++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
        end
        if (accepted) begin
            exp_txn = {exp_addr, exp_link, exp_mis, exp_ill, tag};
            expected_q.push_back(exp_txn);
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: tag %0d not accepted, in_ready %0b, expected 1", tag, in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        for (int n = 0; n < 60 && expected_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        checkOutput(name, expected_q.size(), 0);
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opcode    = '0;
        funct3    = '0;
        rs1       = '0;
        pc        = '0;
        immediate = '0;
        in_tag    = '0;

        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_outputs", {address, link_address, misaligned, illegal, out_tag}, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_in_ready", in_ready, 1);

        // Single LOAD, latency of two cycles
        applyStimulus(OP_LOAD, 3'b010, 32'h0000_1000, 32'h0000_0100, 32'hFFFF_FFFC, 5'd1,
                      32'h0000_0FFC, 32'h0000_0104, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("latency_not_yet", out_valid, 0);
        @(negedge clk);
        checkOutput("latency_valid", out_valid, 1);
        @(posedge clk); #1;
        waitDrain("drain_single");

        // Back-to-back directed vectors
        applyStimulus(OP_JALR,   3'b000, 32'h0000_2001, 32'h0000_0400, 32'h0000_0004, 5'd2,
                      32'h0000_2004, 32'h0000_0404, 1'b0, 1'b0);
        applyStimulus(OP_JALR,   3'b000, 32'h0000_2003, 32'h0000_0400, 32'h0000_0004, 5'd3,
                      32'h0000_2006, 32'h0000_0404, 1'b1, 1'b0);
        applyStimulus(OP_AUIPC,  3'b000, 32'h0000_0000, 32'hFFFF_FFF0, 32'h0000_0020, 5'd4,
                      32'h0000_0010, 32'hFFFF_FFF4, 1'b0, 1'b0);
        applyStimulus(OP_LOAD,   3'b001, 32'h0000_1001, 32'h0000_0500, 32'h0000_0000, 5'd5,
                      32'h0000_1001, 32'h0000_0504, 1'b1, 1'b0);
        applyStimulus(OP_STORE,  3'b010, 32'h0000_1002, 32'h0000_0500, 32'h0000_0000, 5'd6,
                      32'h0000_1002, 32'h0000_0504, 1'b1, 1'b0);
        applyStimulus(OP_STORE,  3'b000, 32'h0000_1003, 32'h0000_0500, 32'h0000_0000, 5'd7,
                      32'h0000_1003, 32'h0000_0504, 1'b0, 1'b0);
        applyStimulus(OP_BRANCH, 3'b000, 32'h0000_0000, 32'h0000_1000, 32'h0000_0002, 5'd8,
                      32'h0000_1002, 32'h0000_1004, 1'b1, 1'b0);
        applyStimulus(OP_JAL,    3'b000, 32'h0000_0000, 32'h0000_1000, 32'h0000_0800, 5'd9,
                      32'h0000_1800, 32'h0000_1004, 1'b0, 1'b0);
        applyStimulus(OP_LOAD,   3'b110, 32'h0000_1002, 32'h0000_0500, 32'h0000_0000, 5'd13,
                      32'h0000_1002, 32'h0000_0504, 1'b1, 1'b0);
        applyStimulus(OP_LOAD,   3'b100, 32'h0000_1003, 32'h0000_0500, 32'h0000_0000, 5'd14,
                      32'h0000_1003, 32'h0000_0504, 1'b0, 1'b0);
        applyStimulus(OP_OP,     3'b000, 32'h0000_1234, 32'h0000_0600, 32'h0000_0008, 5'd15,
                      32'h0000_0000, 32'h0000_0604, 1'b0, 1'b1);
        applyStimulus(OP_STORE,  3'b011, 32'h0000_1000, 32'h0000_0600, 32'h0000_0008, 5'd16,
                      32'h0000_1008, 32'h0000_0604, 1'b0, 1'b1);
        applyStimulus(OP_LOAD,   3'b010, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0004, 5'd17,
                      32'h0000_0002, 32'h0000_0004, 1'b1, 1'b0);
        waitDrain("drain_stream");

        // Back-pressure: four requests, consumer stalled for five cycles
        out_ready = 1'b0;
        fork
            begin
                for (int t = 0; t < 4; t++) begin
                    applyStimulus(OP_LOAD, 3'b010, 32'h0000_3000 + 32'(t * 16), 32'h0000_0200,
                                  32'h0000_0004, 5'(t), 32'h0000_3004 + 32'(t * 16),
                                  32'h0000_0204, 1'b0, 1'b0);
                end
            end
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                checkOutput("bp_in_ready_low", in_ready, 0);
                @(posedge clk);
                @(posedge clk);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDrain("drain_backpressure");

        // Flush together with an accept while two requests are in flight
        out_ready = 1'b0;
        applyStimulus(OP_LOAD, 3'b000, 32'h0000_4000, 32'h0, 32'h0, 5'd10,
                      32'h0000_4000, 32'h0000_0004, 1'b0, 1'b0);
        applyStimulus(OP_LOAD, 3'b000, 32'h0000_4001, 32'h0, 32'h0, 5'd11,
                      32'h0000_4001, 32'h0000_0004, 1'b0, 1'b0);
        out_ready = 1'b1;
        flush     = 1'b1;
        opcode    = OP_LOAD;
        funct3    = 3'b000;
        rs1       = 32'h0000_4002;
        in_tag    = 5'd12;
        in_valid  = 1'b1;
        @(negedge clk);
        checkOutput("flush_in_ready", in_ready, 1);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        expected_q.delete();
        @(negedge clk);
        checkOutput("flush_out_valid", out_valid, 0);
        repeat (6) @(posedge clk);
        #1;

        // Reset in the middle of a stalled stream
        out_ready = 1'b0;
        applyStimulus(OP_JAL, 3'b000, 32'h0, 32'h0000_0800, 32'h0000_0010, 5'd20,
                      32'h0000_0810, 32'h0000_0804, 1'b0, 1'b0);
        applyStimulus(OP_JAL, 3'b000, 32'h0, 32'h0000_0900, 32'h0000_0010, 5'd21,
                      32'h0000_0910, 32'h0000_0904, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        expected_q.delete();
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_outputs", {address, link_address, misaligned, illegal, out_tag}, 0);
        checkOutput("midreset_in_ready", in_ready, 1);
        out_ready = 1'b1;
        applyStimulus(OP_LOAD, 3'b000, 32'h0000_0007, 32'h0000_0008, 32'h0000_0001, 5'd22,
                      32'h0000_0008, 32'h0000_000C, 1'b0, 1'b0);
        waitDrain("drain_after_reset");

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
